// File: rtl/led_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : LED peripheral register map and scheduler FSM encoding.
// Revision : 1.0
// ============================================================================
package led_pkg;

  localparam logic [7:0] LED_ADDR_CTRL    = 8'h01;
  localparam logic [7:0] LED_ADDR_DATA_HI = 8'h02;
  localparam logic [7:0] LED_ADDR_DATA_LO = 8'h03;
  localparam int         LED_CTRL_EN_BIT  = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_HI   = 3'd1,
    S_GAP1   = 3'd2,
    S_W_LO   = 3'd3,
    S_GAP2   = 3'd4,
    S_W_CTRL = 3'd5,
    S_GAP3   = 3'd6,
    S_HOLD   = 3'd7
  } led_state_e;

endpackage
`default_nettype wire

// File: rtl/led_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : led_write_scheduler_if
// Purpose  : Requester inputs and LED register-write port of the scheduler.
// Revision : 1.0
// ============================================================================
interface led_write_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_pattern;
  logic [NUM_REQ-1:0]    req_enable;
  logic [NUM_REQ-1:0]    ack;
  logic                  write_enable;
  logic [7:0]            write_address;
  logic [7:0]            write_data;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  modport master (
    output req, req_pattern, req_enable,
    input  ack, write_enable, write_address, write_data, busy, grant_id
  );

  modport slave (
    input  req, req_pattern, req_enable,
    output ack, write_enable, write_address, write_data, busy, grant_id
  );

endinterface
`default_nettype wire

// File: rtl/led_write_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_rr_arbiter
// Purpose  : Combinational round-robin pick: first set req at or above rr_ptr.
// Revision : 1.0
// ============================================================================
module led_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [GW-1:0]      i_rr_ptr,
  output logic                    o_grant_valid,
  output logic [GW-1:0]           o_grant_idx
);

  logic [GW:0] w_sum;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_sum         = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, i_rr_ptr} + (GW+1)'(i);
      if (w_sum >= (GW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (GW+1)'(NUM_REQ);
      end
      if (i_req[w_sum[GW-1:0]]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_sum[GW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_write_scheduler
// Purpose  : Round-robin share of the LED register-write port; one three-beat
//            burst per grant followed by a minimum display hold.
// Revision : 1.0
// ============================================================================
module led_write_scheduler
  import led_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         HOLD_CYCLES  = 1000,
  parameter logic [7:0] ADDR_CTRL    = LED_ADDR_CTRL,
  parameter logic [7:0] ADDR_DATA_HI = LED_ADDR_DATA_HI,
  parameter logic [7:0] ADDR_DATA_LO = LED_ADDR_DATA_LO
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  led_write_scheduler_if.slave bus
);

  localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] c_hold_last = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : '0;

  led_state_e         r_state;
  led_state_e         w_next_state;
  logic [GW-1:0]      r_grant_id;
  logic [GW-1:0]      r_rr_ptr;
  logic [15:0]        r_pattern;
  logic               r_enable;
  logic [HCW-1:0]     r_hold_cnt;
  logic [7:0]         r_addr;
  logic [7:0]         r_data;
  logic               w_we;
  logic [7:0]         w_addr;
  logic [7:0]         w_data;
  logic [NUM_REQ-1:0] w_ack;
  logic               w_grant_valid;
  logic [GW-1:0]      w_grant_idx;

  led_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_arb (
    .i_req         (bus.req),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_valid) w_next_state = S_W_HI;
      S_W_HI:   w_next_state = S_GAP1;
      S_GAP1:   w_next_state = S_W_LO;
      S_W_LO:   w_next_state = S_GAP2;
      S_GAP2:   w_next_state = S_W_CTRL;
      S_W_CTRL: w_next_state = S_GAP3;
      S_GAP3:   w_next_state = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
      S_HOLD:   if (r_hold_cnt == c_hold_last) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Address/data default to the held copy so gaps keep the last beat visible.
  always_comb begin
    w_we   = 1'b0;
    w_addr = r_addr;
    w_data = r_data;
    w_ack  = '0;
    case (r_state)
      S_W_HI: begin
        w_we   = 1'b1;
        w_addr = ADDR_DATA_HI;
        w_data = r_pattern[15:8];
      end
      S_W_LO: begin
        w_we   = 1'b1;
        w_addr = ADDR_DATA_LO;
        w_data = r_pattern[7:0];
      end
      S_W_CTRL: begin
        w_we                    = 1'b1;
        w_addr                  = ADDR_CTRL;
        w_data                  = '0;
        w_data[LED_CTRL_EN_BIT] = r_enable;
      end
      S_GAP3:  w_ack = NUM_REQ'(1) << r_grant_id;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_pattern  <= '0;
      r_enable   <= 1'b0;
      r_hold_cnt <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_addr <= w_addr;
      r_data <= w_data;
      if (r_state == S_IDLE && w_grant_valid) begin
        r_grant_id <= w_grant_idx;
        r_pattern  <= bus.req_pattern[{w_grant_idx, 4'b0000} +: 16];
        r_enable   <= bus.req_enable[w_grant_idx];
      end
      if (r_state == S_GAP3) begin
        r_rr_ptr   <= (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        r_hold_cnt <= '0;
      end else if (r_state == S_HOLD) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign bus.ack           = w_ack;
  assign bus.write_enable  = w_we;
  assign bus.write_address = w_addr;
  assign bus.write_data    = w_data;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.grant_id      = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_led_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_write_scheduler
// Purpose  : Directed, table-driven bench for led_write_scheduler.
// Revision : 1.0
// ============================================================================
module tb_led_write_scheduler;
  import led_pkg::*;

  localparam int NR = 4;
  localparam int HC = 4;
  localparam logic [63:0] PATS = {16'hBEEF, 16'hFFFF, 16'hA55A, 16'h1234};
  localparam logic [3:0]  ENS  = 4'b1011;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  led_write_scheduler_if #(.NUM_REQ(NR)) bus();

  led_write_scheduler #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] gid;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] ctrl;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic [3:0] ack, input logic busy);
    chk({tag, ".we"},   32'(bus.write_enable),  32'(we));
    chk({tag, ".addr"}, 32'(bus.write_address), 32'(a));
    chk({tag, ".data"}, 32'(bus.write_data),    32'(d));
    chk({tag, ".ack"},  32'(bus.ack),           32'(ack));
    chk({tag, ".busy"}, 32'(bus.busy),          32'(busy));
  endtask

  // Called at a negedge with the DUT idle; scrambles inputs after the grant.
  task automatic run_burst(input vec_t v, input string tag);
    logic [3:0] a;
    a = 4'(1) << v.gid;
    bus.req = v.req;
    @(negedge clk);
    chk_bus({tag, ".whi"}, 1'b1, LED_ADDR_DATA_HI, v.hi, 4'h0, 1'b1);
    chk({tag, ".gid"}, 32'(bus.grant_id), 32'(v.gid));
    bus.req = '0; bus.req_pattern = '0; bus.req_enable = '0;
    @(negedge clk); chk_bus({tag, ".gap1"}, 1'b0, LED_ADDR_DATA_HI, v.hi,   4'h0, 1'b1);
    @(negedge clk); chk_bus({tag, ".wlo"},  1'b1, LED_ADDR_DATA_LO, v.lo,   4'h0, 1'b1);
    @(negedge clk); chk_bus({tag, ".gap2"}, 1'b0, LED_ADDR_DATA_LO, v.lo,   4'h0, 1'b1);
    @(negedge clk); chk_bus({tag, ".wctl"}, 1'b1, LED_ADDR_CTRL,    v.ctrl, 4'h0, 1'b1);
    @(negedge clk); chk_bus({tag, ".gap3"}, 1'b0, LED_ADDR_CTRL,    v.ctrl, a,    1'b1);
    repeat (HC) begin
      @(negedge clk); chk_bus({tag, ".hold"}, 1'b0, LED_ADDR_CTRL, v.ctrl, 4'h0, 1'b1);
    end
    @(negedge clk); chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    bus.req_pattern = PATS; bus.req_enable = ENS;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; bus.req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_whi(input string tag, output logic [1:0] gid);
    bit found;
    found = 1'b0;
    gid   = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.write_enable && bus.write_address == LED_ADDR_DATA_HI) begin
        found = 1'b1;
        gid   = bus.grant_id;
      end
    end
    if (!found) chk({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  int         ack_cyc[8];
  logic [3:0] ack_val[8];
  int         n_ack;
  logic [1:0] g;
  bit         seen;

  initial begin
    vecs[0] = '{4'b0010, 2'd1, 8'hA5, 8'h5A, 8'h01};
    vecs[1] = '{4'b0100, 2'd2, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{4'b0011, 2'd0, 8'h12, 8'h34, 8'h01};
    vecs[3] = '{4'b1001, 2'd3, 8'hBE, 8'hEF, 8'h01};
    vecs[4] = '{4'b1111, 2'd0, 8'h12, 8'h34, 8'h01};
    vecs[5] = '{4'b0101, 2'd2, 8'hFF, 8'hFF, 8'h00};

    bus.req = '0; bus.req_pattern = PATS; bus.req_enable = ENS;

    #1;
    chk_bus("reset", 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    chk("reset.gid", 32'(bus.grant_id), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
    end

    // All four requesting from reset: order 0,1,2,3,0 with 11-cycle spacing.
    do_reset();
    bus.req = 4'b1111;
    n_ack = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.ack != 4'h0 && n_ack < 8) begin
        ack_cyc[n_ack] = c;
        ack_val[n_ack] = bus.ack;
        n_ack++;
      end
    end
    chk("rr.count_ge5", 32'(n_ack >= 5), 32'd1);
    if (n_ack >= 5) begin
      chk("rr.first_cyc", 32'(ack_cyc[0]), 32'd6);
      chk("rr.ack0", 32'(ack_val[0]), 32'h1);
      chk("rr.ack1", 32'(ack_val[1]), 32'h2);
      chk("rr.ack2", 32'(ack_val[2]), 32'h4);
      chk("rr.ack3", 32'(ack_val[3]), 32'h8);
      chk("rr.ack4", 32'(ack_val[4]), 32'h1);
      for (int k = 1; k < 5; k++) begin
        chk($sformatf("rr.spacing%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd11);
      end
    end

    // Reset asserted during W_LO aborts the burst without an ack.
    do_reset();
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    chk_bus("abort.wlo", 1'b1, LED_ADDR_DATA_LO, 8'h34, 4'h0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_bus("abort.async", 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    chk("abort.gid", 32'(bus.grant_id), 32'd0);
    bus.req = 4'b1000;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack != 4'h0) seen = 1'b1;
    end
    chk("abort.no_ack", 32'(seen), 32'd0);
    reset_n = 1'b1;
    run_burst('{4'b1000, 2'd3, 8'hBE, 8'hEF, 8'h01}, "abort.fresh");

    // Requester 2 holds req; requester 0 joins at 2's ack and wins next.
    do_reset();
    bus.req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.ack != 4'h0) seen = 1'b1;
    end
    chk("hold2.ack", 32'(bus.ack), 32'h4);
    bus.req = 4'b0101;
    wait_whi("hold2.next", g);
    chk("hold2.grant_after_wrap", 32'(g), 32'd0);
    wait_whi("hold2.then", g);
    chk("hold2.grant_then", 32'(g), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
